// File: rtl/dma_xfer_pkg.sv
// Shared defaults, count type and FSM encoding for the DMA transfer pipe.
package dma_xfer_pkg;
  localparam int DATA_WIDTH_DEF = 512;
  localparam int SIZE_WIDTH_DEF = 43;

  typedef logic [SIZE_WIDTH_DEF-1:0] count_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dma_xfer_pipe_if.sv
// DMA read/write side handshake; master is the transfer engine, slave the DMA queues.
interface dma_xfer_pipe_if
  import dma_xfer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  rd_empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  wr_full;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (input rd_empty, rd_data, wr_full, output rd_en, wr_en, wr_data);
  modport slave  (output rd_empty, rd_data, wr_full, input rd_en, wr_en, wr_data);
endinterface

// File: rtl/xfer_fifo.sv
// First-word-fall-through buffer with occupancy count and synchronous flush.
module xfer_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/dma_xfer_pipe.sv
// Streams cache lines from the DMA read side through a per-lane add pipeline
// into an output buffer drained by the DMA write side.
module dma_xfer_pipe
  import dma_xfer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [31:0]           lane_add,
  dma_xfer_pipe_if.master       dma,
  output logic                  done,
  output logic [63:0]           busy_cycles
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef logic [SIZE_WIDTH-1:0] cnt_t;

  state_t                state_q, state_d;
  cnt_t                  size_q, size_d, in_count_q, in_count_d, out_count_q, out_count_d;
  logic [31:0]           add_q, add_d;
  logic [63:0]           busy_q, busy_d;
  logic                  run, rd_en, wr_en, push, fifo_empty;
  logic [CW-1:0]         fifo_count, inflight;
  logic [CW:0]           occupancy;
  logic [DATA_WIDTH-1:0] push_data, fifo_head;

  function automatic logic [DATA_WIDTH-1:0] lane_xform(input logic [DATA_WIDTH-1:0] line,
                                                      input logic [31:0] add);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) r[32*i +: 32] = line[32*i +: 32] + add;
    return r;
  endfunction

  assign run       = (state_q == S_RUN);
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  // Credit check counts every line already popped, so the buffer can never overflow.
  assign rd_en     = run && !dma.rd_empty && (in_count_q < size_q) && (occupancy < DEPTH_C);
  assign wr_en     = run && !fifo_empty && !dma.wr_full;

  assign dma.rd_en   = rd_en;
  assign dma.wr_en   = wr_en;
  assign dma.wr_data = fifo_head;
  assign done        = (state_q == S_DONE);
  assign busy_cycles = busy_q;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    add_d       = add_q;
    in_count_d  = in_count_q + cnt_t'(rd_en);
    out_count_d = out_count_q + cnt_t'(wr_en);
    busy_d      = run ? busy_q + 64'd1 : busy_q;
    if (go) begin
      size_d      = size;
      add_d       = lane_add;
      in_count_d  = '0;
      out_count_d = '0;
      busy_d      = '0;
      state_d     = (size == '0) ? S_DONE : S_RUN;
    end else if (run && wr_en && (out_count_d == size_q)) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      add_q       <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      add_q       <= add_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      busy_q      <= busy_d;
    end
  end

  // Stage 1 is the add; the buffer write is the final stage, so LATENCY-1 registers sit between.
  if (LATENCY == 1) begin : g_direct
    assign push      = rd_en;
    assign push_data = lane_xform(dma.rd_data, add_q);
    assign inflight  = '0;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0]         vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q [NS];
    logic [CW-1:0]         inflight_c;

    always_comb begin
      vld_d = '0;
      if (!go) begin
        vld_d[0] = rd_en;
        for (int i = 1; i < NS; i++) vld_d[i] = vld_q[i-1];
      end
    end

    always_comb begin
      inflight_c = '0;
      for (int i = 0; i < NS; i++) inflight_c = inflight_c + CW'(vld_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      data_q[0] <= lane_xform(dma.rd_data, add_q);
      for (int i = 1; i < NS; i++) data_q[i] <= data_q[i-1];
    end

    assign push      = vld_q[NS-1];
    assign push_data = data_q[NS-1];
    assign inflight  = inflight_c;
  end

  xfer_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (go),
    .push      (push),
    .push_data (push_data),
    .pop       (wr_en),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_dma_xfer_pipe.sv
// Directed bench for dma_xfer_pipe: transfer vector table plus backpressure, abort and reset sequences.
module tb_dma_xfer_pipe;
  import dma_xfer_pkg::*;

  localparam int DW    = 512;
  localparam int SW    = SIZE_WIDTH_DEF;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  count_t      size = '0;
  logic [31:0] lane_add = '0;
  logic        done;
  logic [63:0] busy;
  logic [31:0] src_base = '0;
  int          rd_idx = 0;
  int          cyc = 0;

  int checks = 0;
  int failures = 0;

  int          nwr = 0, nrd = 0, wr_total = 0;
  int          first_rd = -1, first_wr = -1, last_wr = -1, done_cyc = -1, go_cyc = 0;
  logic [DW-1:0] wr_log [64];

  dma_xfer_pipe_if #(.DATA_WIDTH(DW)) dma();

  dma_xfer_pipe #(
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SW),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .size        (size),
    .lane_add    (lane_add),
    .dma         (dma),
    .done        (done),
    .busy_cycles (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] make_line(input logic [31:0] base, input int idx);
    logic [DW-1:0] l;
    for (int i = 0; i < DW/32; i++) l[32*i +: 32] = base + 32'(idx*16 + i);
    return l;
  endfunction

  function automatic logic [DW-1:0] expect_line(input logic [31:0] base, input int idx,
                                               input logic [31:0] add);
    logic [DW-1:0] l;
    for (int i = 0; i < DW/32; i++) l[32*i +: 32] = base + 32'(idx*16 + i) + add;
    return l;
  endfunction

  assign dma.rd_data = make_line(src_base, rd_idx);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (go)             rd_idx <= 0;
    else if (dma.rd_en) rd_idx <= rd_idx + 1;
  end

  always @(negedge clk) begin
    if (dma.wr_en) wr_total <= wr_total + 1;
    if (go) begin
      nwr <= 0; nrd <= 0; first_rd <= -1; first_wr <= -1; last_wr <= -1;
      done_cyc <= -1; go_cyc <= cyc;
    end else begin
      if (dma.rd_en) begin
        if (nrd == 0) first_rd <= cyc;
        nrd <= nrd + 1;
      end
      if (dma.wr_en) begin
        if (nwr == 0) first_wr <= cyc;
        last_wr <= cyc;
        if (nwr < 64) wr_log[nwr] <= dma.wr_data;
        nwr <= nwr + 1;
      end
      if (done && done_cyc < 0) done_cyc <= cyc;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic kick(input count_t s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    go = 1'b1; size = s; lane_add = a; src_base = b;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_data(input string nm, input logic [31:0] base, input logic [31:0] add,
                            input int n);
    int bad = 0;
    for (int i = 0; i < n && i < 64; i++)
      if (wr_log[i] !== expect_line(base, i, add)) bad++;
    check(nm, 64'(bad), 64'd0);
  endtask

  typedef struct {
    count_t      size;
    logic [31:0] add;
    logic [31:0] base;
    int          exp_wr;
    logic [31:0] exp_l0;
    logic [31:0] exp_l1;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{size: 4, add: 32'h1,        base: 32'h0,        exp_wr: 4, exp_l0: 32'h1,        exp_l1: 32'h2};
    vecs[1] = '{size: 3, add: 32'h2,        base: 32'hFFFFFFFF, exp_wr: 3, exp_l0: 32'h1,        exp_l1: 32'h2};
    vecs[2] = '{size: 6, add: 32'h10000000, base: 32'h80000000, exp_wr: 6, exp_l0: 32'h90000000, exp_l1: 32'h90000001};
    vecs[3] = '{size: 1, add: 32'hFFFFFFFF, base: 32'h5,        exp_wr: 1, exp_l0: 32'h4,        exp_l1: 32'h5};

    dma.rd_empty = 1'b0;
    dma.wr_full  = 1'b0;

    #1;
    check("rst_done",  64'(done), 64'd0);
    check("rst_rd_en", 64'(dma.rd_en), 64'd0);
    check("rst_wr_en", 64'(dma.wr_en), 64'd0);
    check("rst_busy",  busy, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_rd_en", 64'(dma.rd_en), 64'd0);

    // Zero-length transfer completes immediately.
    kick('0, 32'h0, 32'h0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", busy, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_rd", 64'(nrd), 64'd0);
    check("zero_wr", 64'(nwr), 64'd0);

    for (int v = 0; v < 4; v++) begin
      kick(vecs[v].size, vecs[v].add, vecs[v].base);
      wait_done($sformatf("v%0d_done", v), 200);
      check($sformatf("v%0d_nwr", v), 64'(nwr), 64'(vecs[v].exp_wr));
      check($sformatf("v%0d_nrd", v), 64'(nrd), 64'(vecs[v].exp_wr));
      check_data($sformatf("v%0d_data_bad", v), vecs[v].base, vecs[v].add, vecs[v].exp_wr);
      check($sformatf("v%0d_lane0", v), 64'(wr_log[0][31:0]), 64'(vecs[v].exp_l0));
      check($sformatf("v%0d_lane1", v), 64'(wr_log[0][63:32]), 64'(vecs[v].exp_l1));
      check($sformatf("v%0d_latency", v), 64'(first_wr - first_rd), 64'(LAT));
      check($sformatf("v%0d_done_cyc", v), 64'(done_cyc), 64'(last_wr + 1));
      check($sformatf("v%0d_busy", v), busy, 64'(last_wr - go_cyc));
    end

    // Backpressure: credits stop reads once the buffer plus pipeline hold DEPTH lines.
    dma.wr_full = 1'b1;
    kick(20, 32'h3, 32'h100);
    repeat (30) @(posedge clk);
    #1;
    check("bp_rd_stall", 64'(nrd), 64'(DEPTH));
    check("bp_wr_stall", 64'(nwr), 64'd0);
    dma.wr_full = 1'b0;
    wait_done("bp_done", 300);
    check("bp_nwr", 64'(nwr), 64'd20);
    check("bp_nrd", 64'(nrd), 64'd20);
    check_data("bp_data_bad", 32'h100, 32'h3, 20);

    // Abort after five writes and restart with a shorter transfer.
    kick(10, 32'h1, 32'h0);
    for (int n = 0; n < 100 && nwr < 5; n++) begin
      @(posedge clk); #1;
    end
    check("ab_first_wr", 64'(nwr), 64'd5);
    dma.wr_full = 1'b1;
    go = 1'b1; size = 3; lane_add = 32'h7; src_base = 32'h500;
    @(posedge clk); #1;
    go = 1'b0;
    dma.wr_full = 1'b0;
    wait_done("ab_done", 200);
    check("ab_nwr", 64'(nwr), 64'd3);
    check_data("ab_data_bad", 32'h500, 32'h7, 3);
    repeat (5) @(posedge clk);
    #1;
    check("ab_nwr_after", 64'(nwr), 64'd3);

    // Reset with lines in flight discards them.
    dma.wr_full = 1'b1;
    kick(8, 32'h1, 32'h40);
    for (int n = 0; n < 100 && nrd < 4; n++) begin
      @(posedge clk); #1;
    end
    check("rr_inflight", 64'(nrd), 64'd4);
    rst_n = 1'b0;
    #1;
    check("rr_rd_en", 64'(dma.rd_en), 64'd0);
    check("rr_wr_en", 64'(dma.wr_en), 64'd0);
    check("rr_done",  64'(done), 64'd0);
    check("rr_busy",  busy, 64'd0);
    begin
      int snap;
      snap = wr_total;
      dma.wr_full = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("rr_no_wr", 64'(wr_total), 64'(snap));
      check("rr_idle_done", 64'(done), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
